packet_stream_arbiter: RTL and testbench

Packet-granular round-robin arbiter that merges up to N_SRC Avalon-ST 64-bit sources into the single sink port of the packet classer. Once a source wins, it holds the grant until its endofpacket beat is accepted, so packets are never interleaved. A 2-entry skid buffer gives a registered output at full throughput. The winning source index travels on the output channel for downstream accounting.

---
 rtl/pkt_arb_pkg.sv | 23 ++
 rtl/ast_skid_buffer.sv | 68 ++++++
 rtl/packet_stream_arbiter.sv | 138 +++++++++++++
 tb/tb_packet_stream_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types for the packet arbiter and the classer it feeds:
// beat struct, arbiter FSM states and default stream widths.
package pkt_arb_pkg;

    localparam int PKT_DATA_W  = 64;
    localparam int PKT_EMPTY_W = 3;
    localparam int PKT_N_SRC   = 4;
    localparam int PKT_CH_W    = $clog2(PKT_N_SRC);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [PKT_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [PKT_EMPTY_W-1:0] empty;
        logic [PKT_CH_W-1:0]    channel;
    } beat_t;

endpackage

// File: rtl/ast_skid_buffer.sv
// Two-entry skid buffer with a registered head; full throughput.
// Ports: clk_i, arst_i, in_valid_i/in_ready_o/in_data_i (push side),
// out_valid_o/out_ready_i/out_data_o (pop side, head entry).
module ast_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign pop         = out_valid_o & out_ready_i;
    // A full buffer still accepts when the head leaves this cycle.
    assign in_ready_o  = (count_q != 2'd2) | pop;
    assign push        = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_data_i;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= in_data_i;
                    end else if (push) begin
                        tail_q  <= in_data_i;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= in_data_i;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/packet_stream_arbiter.sv
// Packet-granular round-robin merge of N_SRC Avalon-ST sources into one
// sink. Ports: src_* per-source streams + src_enable_i mask, ast_* merged
// output with source index on ast_channel_o, err_o sticky SOP-error flags.
module packet_stream_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int N_SRC   = PKT_N_SRC,
    parameter int DATA_W  = PKT_DATA_W,
    parameter int EMPTY_W = PKT_EMPTY_W
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic [N_SRC-1:0]           src_valid_i,
    input  logic [N_SRC*DATA_W-1:0]    src_data_i,
    input  logic [N_SRC-1:0]           src_startofpacket_i,
    input  logic [N_SRC-1:0]           src_endofpacket_i,
    input  logic [N_SRC*EMPTY_W-1:0]   src_empty_i,
    output logic [N_SRC-1:0]           src_ready_o,
    input  logic [N_SRC-1:0]           src_enable_i,
    input  logic                       ast_ready_i,
    output logic                       ast_valid_o,
    output logic [DATA_W-1:0]          ast_data_o,
    output logic                       ast_startofpacket_o,
    output logic                       ast_endofpacket_o,
    output logic [EMPTY_W-1:0]         ast_empty_o,
    output logic [$clog2(N_SRC)-1:0]   ast_channel_o,
    output logic [N_SRC-1:0]           err_o
);

    localparam int CH_W = $clog2(N_SRC);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]  err_q;
    logic [N_SRC-1:0]  cand;
    logic [N_SRC-1:0]  flush;
    logic [CH_W-1:0]   pick;
    logic              push_valid;
    logic              buf_ready;
    logic              buf_valid;
    beat_t             push_beat;
    beat_t             head_beat;

    // First requester at or after ptr, wrapping. Scanning from the far
    // end lets the nearest match overwrite the others.
    function automatic logic [CH_W-1:0] rr_pick(
        input logic [N_SRC-1:0] req,
        input logic [CH_W-1:0]  ptr
    );
        logic [CH_W-1:0] sel;
        sel = ptr;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            int k;
            k = (int'(ptr) + i) % N_SRC;
            if (req[k]) sel = CH_W'(k);
        end
        return sel;
    endfunction

    assign cand = src_valid_i & src_startofpacket_i & src_enable_i;
    assign pick = rr_pick(cand, rr_ptr_q);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_q | flush;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        src_ready_o = '0;
        flush       = '0;
        push_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Mid-packet beats with no owner are drained and flagged.
                flush       = src_valid_i & ~src_startofpacket_i;
                src_ready_o = flush;
                if (|cand) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                src_ready_o[grant_q] = buf_ready;
                push_valid           = src_valid_i[grant_q];
                if (push_valid && buf_ready &&
                    src_endofpacket_i[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == CH_W'(N_SRC - 1)) ?
                               '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_beat.data    = src_data_i[int'(grant_q)*DATA_W +: DATA_W];
        push_beat.sop     = src_startofpacket_i[grant_q];
        push_beat.eop     = src_endofpacket_i[grant_q];
        push_beat.empty   = src_empty_i[int'(grant_q)*EMPTY_W +: EMPTY_W];
        push_beat.channel = grant_q;
    end

    ast_skid_buffer #(
        .W($bits(beat_t))
    ) u_skid (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .in_valid_i  (push_valid),
        .in_ready_o  (buf_ready),
        .in_data_i   (push_beat),
        .out_valid_o (buf_valid),
        .out_ready_i (ast_ready_i),
        .out_data_o  (head_beat)
    );

    assign ast_valid_o         = buf_valid;
    assign ast_data_o          = head_beat.data;
    assign ast_startofpacket_o = head_beat.sop;
    assign ast_endofpacket_o   = head_beat.eop;
    assign ast_empty_o         = head_beat.empty;
    assign ast_channel_o       = head_beat.channel;
    assign err_o               = err_q;

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Self-checking bench for packet_stream_arbiter: queue-driven sources,
// packet-level round-robin model and an output scoreboard.
module tb_packet_stream_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        bad;
    } sbeat_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        int          ch;
    } obeat_t;

    logic           clk_i = 1'b0;
    logic           arst_i;
    logic [N-1:0]   src_valid_i;
    logic [N*64-1:0] src_data_i;
    logic [N-1:0]   src_startofpacket_i;
    logic [N-1:0]   src_endofpacket_i;
    logic [N*3-1:0] src_empty_i;
    logic [N-1:0]   src_ready_o;
    logic [N-1:0]   src_enable_i;
    logic           ast_ready_i;
    logic           ast_valid_o;
    logic [63:0]    ast_data_o;
    logic           ast_startofpacket_o;
    logic           ast_endofpacket_o;
    logic [2:0]     ast_empty_o;
    logic [1:0]     ast_channel_o;
    logic [N-1:0]   err_o;

    packet_stream_arbiter dut (
        .clk_i               (clk_i),
        .arst_i              (arst_i),
        .src_valid_i         (src_valid_i),
        .src_data_i          (src_data_i),
        .src_startofpacket_i (src_startofpacket_i),
        .src_endofpacket_i   (src_endofpacket_i),
        .src_empty_i         (src_empty_i),
        .src_ready_o         (src_ready_o),
        .src_enable_i        (src_enable_i),
        .ast_ready_i         (ast_ready_i),
        .ast_valid_o         (ast_valid_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .err_o               (err_o)
    );

    always #5 clk_i = ~clk_i;

    sbeat_t srcq [N][$];
    sbeat_t planq[N][$];
    obeat_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_out = -1;
    int occ      = 0;
    int m_ptr    = 0;
    int cur_src  = 0;
    int rdy_mode = 0;
    bit in_pkt   = 0;
    bit gap_chk  = 0;
    bit gap_on   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        sbeat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = {$urandom, $urandom};
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = b.eop ? 3'($urandom_range(0, 7)) : 3'd0;
            b.bad   = 1'b0;
            srcq[s].push_back(b);
            planq[s].push_back(b);
        end
    endtask

    // Packet-level round robin: whole packets in grant order, each from
    // the first enabled source with work at or after the pointer.
    task automatic plan(input logic [N-1:0] en);
        bit     done;
        int     pk;
        sbeat_t b;
        obeat_t o;
        done = 0;
        while (!done) begin
            pk = -1;
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (pk < 0 && en[s] && planq[s].size() > 0) pk = s;
            end
            if (pk < 0) begin
                done = 1;
            end else begin
                do begin
                    b = planq[pk].pop_front();
                    o = '{b.data, b.sop, b.eop, b.empty, pk};
                    exp_q.push_back(o);
                end while (!b.eop);
                m_ptr = (pk + 1) % N;
            end
        end
    endtask

    task automatic drive();
        sbeat_t b;
        for (int s = 0; s < N; s++) begin
            if (srcq[s].size() > 0) begin
                b = srcq[s][0];
                src_valid_i[s] = !(gap_on && !b.sop &&
                                   $urandom_range(0, 3) == 0);
                src_data_i[s*64 +: 64]  = b.data;
                src_startofpacket_i[s]  = b.sop;
                src_endofpacket_i[s]    = b.eop;
                src_empty_i[s*3 +: 3]   = b.empty;
            end else begin
                src_valid_i[s]          = 1'b0;
                src_data_i[s*64 +: 64]  = '0;
                src_startofpacket_i[s]  = 1'b0;
                src_endofpacket_i[s]    = 1'b0;
                src_empty_i[s*3 +: 3]   = '0;
            end
        end
        case (rdy_mode)
            1:       ast_ready_i = ~ast_ready_i;
            2:       ast_ready_i = ($urandom_range(0, 3) != 0);
            default: ast_ready_i = 1'b1;
        endcase
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        bit           push;
        bit           pop;
        obeat_t       e;
        sbeat_t       b;
        @(negedge clk_i);
        acc  = src_valid_i & src_ready_o;
        pop  = ast_valid_o && ast_ready_i;
        push = 0;
        for (int s = 0; s < N; s++)
            if (acc[s] && !srcq[s][0].bad) push = 1;
        chk("valid_vs_occupancy", ast_valid_o, occ != 0);
        if (in_pkt) begin
            chk("ready_granted", src_ready_o[cur_src],
                (occ < 2) || ast_ready_i);
            chk("ready_others", src_ready_o & ~(4'd1 << cur_src), 0);
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", ast_data_o, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", ast_data_o, e.data);
                chk("out_sop", ast_startofpacket_o, e.sop);
                chk("out_eop", ast_endofpacket_o, e.eop);
                chk("out_empty", ast_empty_o, e.empty);
                chk("out_channel", ast_channel_o, e.ch);
            end
            if (gap_chk) begin
                if (last_out >= 0) chk("beat_gap", cyc - last_out, 2);
                last_out = cyc;
            end
        end
        @(posedge clk_i);
        #1;
        for (int s = 0; s < N; s++) begin
            if (acc[s]) begin
                b = srcq[s].pop_front();
                if (!b.bad) begin
                    if (b.eop) begin
                        in_pkt = 0;
                    end else if (b.sop) begin
                        in_pkt  = 1;
                        cur_src = s;
                    end
                end
            end
        end
        occ = occ + int'(push) - int'(pop);
        drive();
    endtask

    task automatic drain(input logic [N-1:0] mask, input int max);
        int n;
        bit busy;
        n = 0;
        drive();
        busy = 1;
        while (busy && n < max) begin
            busy = (exp_q.size() > 0);
            for (int s = 0; s < N; s++)
                if (mask[s] && srcq[s].size() > 0) busy = 1;
            if (busy) begin
                tick();
                n++;
            end
        end
        chk("drain_timeout", n < max, 1);
    endtask

    initial begin
        obeat_t o;
        sbeat_t b;
        int     n;

        arst_i              = 1'b1;
        src_valid_i         = '0;
        src_data_i          = '0;
        src_startofpacket_i = '0;
        src_endofpacket_i   = '0;
        src_empty_i         = '0;
        src_enable_i        = 4'hF;
        ast_ready_i         = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", ast_valid_o, 0);
        chk("rst_data", ast_data_o, 0);
        chk("rst_sop_eop", {ast_startofpacket_o, ast_endofpacket_o}, 0);
        chk("rst_empty", ast_empty_o, 0);
        chk("rst_channel", ast_channel_o, 0);
        chk("rst_ready", src_ready_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;

        // Two 3-beat packets from reset, then one beat on every source.
        add_pkt(0, 3);
        add_pkt(2, 3);
        plan(4'hF);
        drain(4'hF, 100);
        for (int s = 0; s < N; s++) add_pkt(s, 1);
        plan(4'hF);
        drain(4'hF, 100);

        // Back-to-back single-beat packets: one beat every two cycles.
        for (int p = 0; p < 8; p++)
            for (int s = 0; s < N; s++) add_pkt(s, 1);
        plan(4'hF);
        gap_chk  = 1;
        last_out = -1;
        drain(4'hF, 200);
        gap_chk = 0;

        // Toggling sink ready through an 8-beat packet.
        rdy_mode = 1;
        add_pkt(0, 8);
        plan(4'hF);
        drain(4'hF, 100);
        rdy_mode = 0;

        // Orphan non-SOP beat on source 1, then a proper packet.
        b = '{64'hDEAD, 1'b0, 1'b0, 3'd0, 1'b1};
        srcq[1].push_back(b);
        add_pkt(1, 2);
        plan(4'hF);
        drain(4'hF, 100);
        chk("err_after_orphan", err_o, 4'b0010);

        // Source 2 masked while everybody requests.
        src_enable_i = 4'b1011;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) add_pkt(s, 1);
        plan(4'b1011);
        drain(4'b1011, 200);
        chk("masked_src_pending", srcq[2].size(), 3);
        srcq[2].delete();
        planq[2].delete();
        src_enable_i = 4'hF;
        drain(4'hF, 10);
        chk("err_sticky", err_o, 4'b0010);

        // Random lengths, mid-packet valid gaps, random backpressure.
        gap_on   = 1;
        rdy_mode = 2;
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 6; p++) add_pkt(s, $urandom_range(1, 5));
        plan(4'hF);
        drain(4'hF, 4000);
        gap_on   = 0;
        rdy_mode = 0;

        // Reset with beat 2 of a 4-beat packet sitting in the buffer.
        add_pkt(0, 4);
        b = planq[0].pop_front();
        o = '{b.data, b.sop, b.eop, b.empty, 0};
        exp_q.push_back(o);
        planq[0].delete();
        drive();
        n = 0;
        while (srcq[0].size() > 2 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_pkt_timeout", n < 50, 1);
        chk("beat1_out", exp_q.size(), 0);
        chk("pre_reset_valid", ast_valid_o, 1);
        arst_i = 1'b1;
        srcq[0].delete();
        drive();
        #1;
        chk("reset_valid_now", ast_valid_o, 0);
        chk("reset_err", err_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_held_valid", ast_valid_o, 0);
        chk("reset_held_ready", src_ready_o, 0);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        occ    = 0;
        in_pkt = 0;
        m_ptr  = 0;
        add_pkt(3, 2);
        add_pkt(1, 3);
        plan(4'hF);
        drain(4'hF, 100);
        chk("post_reset_err", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
